// File: rtl/sram_axi_bridge_mc_pkg.sv
// sram_axi_bridge_mc_pkg: AXI constants, ID width and channel limit shared by the bridge.
package sram_axi_bridge_mc_pkg;
   localparam int ID_W = 4;
   localparam int MAX_CH = 16;
   localparam logic [1:0] BURST_INCR = 2'b01;
   typedef enum logic [1:0] {SZ_BYTE = 2'd0, SZ_HALF = 2'd1, SZ_WORD = 2'd2} size_e;
   function automatic logic [ID_W-1:0] oh_to_id(input logic [MAX_CH-1:0] oh);
      oh_to_id = '0;
      for (int i = 0; i < MAX_CH; i++)
         if (oh[i]) oh_to_id = ID_W'(i);
   endfunction
endpackage

// File: rtl/sram_axi_bridge_mc_rr_arbiter.sv
// rr_arbiter: round-robin arbiter; the pointer moves past the winner only when advance is high.
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);
   localparam int PW = N > 1 ? $clog2(N) : 1;
   logic [PW-1:0] ptr_q, ptr_d;
   int idx;
   // Scan from the farthest offset down so the request nearest the pointer wins.
   always_comb begin
      grant = '0;
      ptr_d = ptr_q;
      idx = 0;
      for (int k = N - 1; k >= 0; k--) begin
         idx = (int'(ptr_q) + k) % N;
         if (req[idx]) begin
            grant = '0;
            grant[idx] = 1'b1;
            ptr_d = advance ? PW'((idx + 1) % N) : ptr_q;
         end
      end
   end
   always_ff @(posedge aclk) begin
      if (areset) ptr_q <= '0;
      else ptr_q <= ptr_d;
   end
endmodule

// File: rtl/sram_axi_bridge_mc.sv
// sram_axi_bridge_mc: round-robin bridge from NUM_CH SRAM-like ports onto one AXI3 master,
// with per-channel outstanding reads routed by ID and a single read-after-write-safe write.
module sram_axi_bridge_mc
   import sram_axi_bridge_mc_pkg::*;
#(
   parameter int NUM_CH   = 2,
   parameter int RD_OUTST = 4
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic [NUM_CH-1:0]    ch_req,
   input  logic [NUM_CH-1:0]    ch_wr,
   input  logic [2*NUM_CH-1:0]  ch_size,
   input  logic [32*NUM_CH-1:0] ch_addr,
   input  logic [32*NUM_CH-1:0] ch_wdata,
   input  logic [4*NUM_CH-1:0]  ch_wstrb,
   output logic [NUM_CH-1:0]    ch_addr_ok,
   output logic [NUM_CH-1:0]    ch_data_ok,
   output logic [31:0]          ch_rdata,
   output logic [3:0]           arid,
   output logic [31:0]          araddr,
   output logic [7:0]           arlen,
   output logic [2:0]           arsize,
   output logic [1:0]           arburst,
   output logic [1:0]           arlock,
   output logic [3:0]           arcache,
   output logic [2:0]           arprot,
   output logic                 arvalid,
   input  logic                 arready,
   input  logic [3:0]           rid,
   input  logic [31:0]          rdata,
   input  logic [1:0]           rresp,
   input  logic                 rlast,
   input  logic                 rvalid,
   output logic                 rready,
   output logic [3:0]           awid,
   output logic [31:0]          awaddr,
   output logic [7:0]           awlen,
   output logic [2:0]           awsize,
   output logic [1:0]           awburst,
   output logic [1:0]           awlock,
   output logic [3:0]           awcache,
   output logic [2:0]           awprot,
   output logic                 awvalid,
   input  logic                 awready,
   output logic [3:0]           wid,
   output logic [31:0]          wdata,
   output logic [3:0]           wstrb,
   output logic                 wlast,
   output logic                 wvalid,
   input  logic                 wready,
   input  logic [3:0]           bid,
   input  logic [1:0]           bresp,
   input  logic                 bvalid,
   output logic                 bready
);
   localparam int CW = $clog2(RD_OUTST) + 1;
   logic [NUM_CH-1:0] rd_req, wr_req, rd_arb, wr_arb, rd_gnt, wr_gnt, r_hit, b_hit;
   logic ar_free, aw_free, unused;
   logic [CW-1:0] cnt_q [NUM_CH];
   logic [CW-1:0] cnt_d [NUM_CH];
   logic arvalid_q, arvalid_d, awvalid_q, awvalid_d, wvalid_q, wvalid_d, wpend_q, wpend_d;
   logic [ID_W-1:0] arid_q, arid_d, awid_q, awid_d;
   logic [31:0] araddr_q, araddr_d, awaddr_q, awaddr_d, wdata_q, wdata_d;
   logic [2:0] arsize_q, arsize_d, awsize_q, awsize_d;
   logic [3:0] wstrb_q, wstrb_d;
   logic [31:0] rd_addr, wr_addr, wr_data;
   logic [1:0] rd_size, wr_size;
   logic [3:0] wr_strb;
   assign unused = ^{rresp, rlast, bresp};
   assign bready = ~(rvalid & (rid == bid));
   // awaddr_q keeps the pending write's address until its B beat, so it doubles as the RAW tag.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         rd_req[i] = ch_req[i] & ~ch_wr[i] & (cnt_q[i] < CW'(RD_OUTST))
                   & ~(wpend_q & (ch_addr[32*i+2 +: 30] == awaddr_q[31:2]));
         wr_req[i] = ch_req[i] & ch_wr[i];
         r_hit[i] = rvalid & (rid == ID_W'(i)) & (cnt_q[i] != '0);
         b_hit[i] = bvalid & bready & wpend_q & (bid == ID_W'(i));
      end
   end
   assign ar_free = ~arvalid_q | arready;
   assign aw_free = ~wpend_q;
   rr_arbiter #(.N(NUM_CH)) u_rd_arb (
      .aclk(aclk), .areset(areset), .req(rd_req), .advance(ar_free), .grant(rd_arb)
   );
   rr_arbiter #(.N(NUM_CH)) u_wr_arb (
      .aclk(aclk), .areset(areset), .req(wr_req), .advance(aw_free), .grant(wr_arb)
   );
   assign rd_gnt = ar_free ? rd_arb : '0;
   assign wr_gnt = aw_free ? wr_arb : '0;
   assign ch_addr_ok = rd_gnt | wr_gnt;
   assign ch_data_ok = r_hit | b_hit;
   assign ch_rdata = |r_hit ? rdata : '0;
   always_comb begin
      rd_addr = '0;
      rd_size = '0;
      wr_addr = '0;
      wr_size = '0;
      wr_data = '0;
      wr_strb = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (rd_gnt[i]) begin
            rd_addr = ch_addr[32*i +: 32];
            rd_size = ch_size[2*i +: 2];
         end
         if (wr_gnt[i]) begin
            wr_addr = ch_addr[32*i +: 32];
            wr_size = ch_size[2*i +: 2];
            wr_data = ch_wdata[32*i +: 32];
            wr_strb = ch_wstrb[4*i +: 4];
         end
      end
   end
   always_comb begin
      arvalid_d = |rd_gnt | (arvalid_q & ~arready);
      arid_d = |rd_gnt ? oh_to_id(MAX_CH'(rd_gnt)) : arid_q;
      araddr_d = |rd_gnt ? rd_addr : araddr_q;
      arsize_d = |rd_gnt ? {1'b0, rd_size} : arsize_q;
      awvalid_d = |wr_gnt | (awvalid_q & ~awready);
      wvalid_d = |wr_gnt | (wvalid_q & ~wready);
      awid_d = |wr_gnt ? oh_to_id(MAX_CH'(wr_gnt)) : awid_q;
      awaddr_d = |wr_gnt ? wr_addr : awaddr_q;
      awsize_d = |wr_gnt ? {1'b0, wr_size} : awsize_q;
      wdata_d = |wr_gnt ? wr_data : wdata_q;
      wstrb_d = |wr_gnt ? wr_strb : wstrb_q;
      wpend_d = |wr_gnt | (wpend_q & ~|b_hit);
      for (int i = 0; i < NUM_CH; i++)
         cnt_d[i] = cnt_q[i] + CW'(rd_gnt[i]) - CW'(r_hit[i]);
   end
   always_ff @(posedge aclk) begin
      if (areset) begin
         arvalid_q <= 1'b0;
         awvalid_q <= 1'b0;
         wvalid_q <= 1'b0;
         wpend_q <= 1'b0;
         arid_q <= '0;
         awid_q <= '0;
         araddr_q <= '0;
         awaddr_q <= '0;
         arsize_q <= '0;
         awsize_q <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
      end else begin
         arvalid_q <= arvalid_d;
         awvalid_q <= awvalid_d;
         wvalid_q <= wvalid_d;
         wpend_q <= wpend_d;
         arid_q <= arid_d;
         awid_q <= awid_d;
         araddr_q <= araddr_d;
         awaddr_q <= awaddr_d;
         arsize_q <= arsize_d;
         awsize_q <= awsize_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= cnt_d[i];
      end
   end
   assign arvalid = arvalid_q;
   assign arid = arid_q;
   assign araddr = araddr_q;
   assign arsize = arsize_q;
   assign arlen = 8'd0;
   assign arburst = BURST_INCR;
   assign arlock = 2'd0;
   assign arcache = 4'd0;
   assign arprot = 3'd0;
   assign rready = 1'b1;
   assign awvalid = awvalid_q;
   assign awid = awid_q;
   assign awaddr = awaddr_q;
   assign awsize = awsize_q;
   assign awlen = 8'd0;
   assign awburst = BURST_INCR;
   assign awlock = 2'd0;
   assign awcache = 4'd0;
   assign awprot = 3'd0;
   assign wvalid = wvalid_q;
   assign wid = awid_q;
   assign wdata = wdata_q;
   assign wstrb = wstrb_q;
   assign wlast = 1'b1;
endmodule
